// File: rtl/calculo_preco_total.sv
// calculo_preco_total
// Sequential price calculator: total = round(peso_g * preco / 1000) in cents.
// Uses a 12-step shift-add multiplier followed by a 21-step restoring
// divider by the constant 1000, under a start/busy/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a calculation (sampled when no calculation is running)
//   peso_g     weight in grams, captured on the accepting start edge
//   preco_fil  filtered price per kg in cents, captured on the start edge
//   busy       high while the multiply/divide sequence is running
//   done       one-cycle pulse when total/erro are valid
//   total      amount in cents, held until the next done
//   erro       overweight flag, updated together with done
module calculo_preco_total #(
    parameter int unsigned W_PESO    = 12,
    parameter int unsigned W_PRECO   = 9,
    parameter int unsigned W_TOTAL   = 12,
    parameter int unsigned PESO_MAX  = 4000,
    parameter int unsigned PRECO_MAX = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W_PESO-1:0]  peso_g,
    input  logic [W_PRECO-1:0] preco_fil,
    output logic               busy,
    output logic               done,
    output logic [W_TOTAL-1:0] total,
    output logic               erro
);

    localparam int unsigned W_ACC   = 21;   // 4095*500 + 500 < 2^21
    localparam int unsigned W_REM   = 11;   // remainder < 1000, shifted < 2000
    localparam int unsigned W_CNT   = 5;
    localparam int unsigned W_SHIFT = 4;

    localparam logic [W_CNT-1:0] MULT_LAST = W_CNT'(W_PESO - 1);
    localparam logic [W_CNT-1:0] DIV_LAST  = W_CNT'(W_ACC - 1);
    localparam logic [W_REM-1:0] DIVISOR   = W_REM'(1000);
    localparam logic [W_ACC-1:0] ROUND_ADD = W_ACC'(500);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [W_PRECO-1:0]   preco_r, preco_n;
    logic [W_PESO-1:0]    peso_r, peso_n;
    logic                 ovf, ovf_n;
    logic [W_ACC-1:0]     acc, acc_n;
    logic [W_REM-1:0]     rem, rem_n;
    logic [W_CNT-1:0]     cnt, cnt_n;
    logic                 busy_n;
    logic                 done_n;
    logic [W_TOTAL-1:0]   total_n;
    logic                 erro_n;

    logic [W_ACC-1:0]     addend;
    logic [W_REM-1:0]     shifted;
    logic                 qbit;
    logic [W_PRECO-1:0]   preco_clamp;

    // Price clamp applied at capture
    always_comb begin
        preco_clamp = preco_fil;
        if (preco_fil > W_PRECO'(PRECO_MAX)) begin
            preco_clamp = W_PRECO'(PRECO_MAX);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            preco_r <= '0;
            peso_r  <= '0;
            ovf     <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            total   <= '0;
            erro    <= 1'b0;
        end else begin
            state   <= state_n;
            preco_r <= preco_n;
            peso_r  <= peso_n;
            ovf     <= ovf_n;
            acc     <= acc_n;
            rem     <= rem_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            total   <= total_n;
            erro    <= erro_n;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_n = state;
        preco_n = preco_r;
        peso_n  = peso_r;
        ovf_n   = ovf;
        acc_n   = acc;
        rem_n   = rem;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        total_n = total;
        erro_n  = erro;
        addend  = '0;
        shifted = '0;
        qbit    = 1'b0;

        unique case (state)
            // DONE behaves like IDLE for a new request, so a held start
            // yields one result every 34 cycles.
            IDLE, DONE: begin
                busy_n = 1'b0;
                if (start) begin
                    preco_n = preco_clamp;
                    peso_n  = peso_g;
                    ovf_n   = (peso_g > W_PESO'(PESO_MAX));
                    acc_n   = '0;
                    rem_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = MULT;
                end else begin
                    state_n = IDLE;
                end
            end

            // One partial product per cycle, LSB first; rounding constant
            // folded into the last addition.
            MULT: begin
                if (peso_r[cnt[W_SHIFT-1:0]]) begin
                    addend = W_ACC'(preco_r) << cnt[W_SHIFT-1:0];
                end
                if (cnt == MULT_LAST) begin
                    acc_n   = acc + addend + ROUND_ADD;
                    cnt_n   = '0;
                    state_n = DIV;
                end else begin
                    acc_n   = acc + addend;
                    cnt_n   = cnt + W_CNT'(1);
                end
            end

            // Restoring division by 1000, MSB first; quotient bits shift
            // into acc as the dividend bits shift out.
            DIV: begin
                shifted = {rem[W_REM-2:0], acc[W_ACC-1]};
                if (shifted >= DIVISOR) begin
                    rem_n = shifted - DIVISOR;
                    qbit  = 1'b1;
                end else begin
                    rem_n = shifted;
                    qbit  = 1'b0;
                end
                acc_n = {acc[W_ACC-2:0], qbit};
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    total_n = ovf ? '0 : acc_n[W_TOTAL-1:0];
                    erro_n  = ovf;
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt + W_CNT'(1);
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_calculo_preco_total.sv
// Scoreboard bench for calculo_preco_total: stimulus pushes expected
// results (value, flag, arrival cycle); a monitor pops on every done.
module tb_calculo_preco_total;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] peso_g;
    logic [8:0]  preco_fil;
    logic        busy;
    logic        done;
    logic [11:0] total;
    logic        erro;

    typedef struct {
        logic [11:0] total;
        logic        erro;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;

    calculo_preco_total dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .peso_g    (peso_g),
        .preco_fil (preco_fil),
        .busy      (busy),
        .done      (done),
        .total     (total),
        .erro      (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one start pulse; expected result due 33 edges after acceptance.
    task automatic issue(input logic [11:0] p, input logic [8:0] pr,
                         input logic [11:0] et, input logic ee);
        exp_t e;
        @(negedge clk);
        peso_g    = p;
        preco_fil = pr;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e.total = et;
        e.erro  = ee;
        e.cyc   = cyc + 33;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results pending after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [11:0] p, input logic [8:0] pr,
                       input logic [11:0] et, input logic ee);
        issue(p, pr, et, ee);
        wait_drain(60);
    endtask

    initial begin
        int   busy_cnt;
        exp_t e;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        peso_g    = '0;
        preco_fil = '0;

        // Monitor: every done must match the head of the scoreboard
        fork
            forever begin
                @(negedge clk);
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d total %0d)", cyc, total);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("total", int'(total), int'(e.total));
                        check("erro", int'(erro), int'(e.erro));
                        check("busy_at_done", int'(busy), 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_total", int'(total), 0);
        check("rst_erro", int'(erro), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic case with busy-length measurement
        issue(12'd1000, 9'd250, 12'd250, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else break;
        end
        check("busy_cycles", busy_cnt, 33);
        wait_drain(60);

        // Rounding and boundaries
        run(12'd1500, 9'd199, 12'd299, 1'b0);
        run(12'd333,  9'd3,   12'd1,   1'b0);
        run(12'd1,    9'd499, 12'd0,   1'b0);
        run(12'd4000, 9'd500, 12'd2000, 1'b0);
        run(12'd4001, 9'd100, 12'd0,   1'b1);
        run(12'd0,    9'd500, 12'd0,   1'b0);
        run(12'd1000, 9'd511, 12'd500, 1'b0);
        run(12'd2000, 9'd0,   12'd0,   1'b0);
        run(12'd4095, 9'd500, 12'd0,   1'b1);
        run(12'd2500, 9'd123, 12'd308, 1'b0);

        // Start and operand changes while busy are ignored
        issue(12'd1000, 9'd250, 12'd250, 1'b0);
        repeat (5) @(negedge clk);
        peso_g    = 12'd4000;
        preco_fil = 9'd500;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_drain(60);
        repeat (40) @(negedge clk);

        // Reset in the middle of a calculation
        issue(12'd1500, 9'd199, 12'd299, 1'b0);
        repeat (9) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_total", int'(total), 0);
        check("abort_erro", int'(erro), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_after_abort", int'(busy), 0);

        // Held start: results every 34 cycles
        @(negedge clk);
        peso_g    = 12'd1000;
        preco_fil = 9'd100;
        start     = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            e.total = 12'd100;
            e.erro  = 1'b0;
            e.cyc   = cyc + 33;
            exp_q.push_back(e);
            if (n < 2) repeat (33) @(posedge clk);
        end
        start = 1'b0;
        wait_drain(60);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
